// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, access sizes,
// alignment rule and counter sizing.
package dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // mem_byte wins over mem_half_word; neither means a full word.
  function automatic size_e decode_size(input logic mem_byte, input logic mem_half_word);
    size_e sz;
    if (mem_byte)           sz = SZ_BYTE;
    else if (mem_half_word) sz = SZ_HALF;
    else                    sz = SZ_WORD;
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lsb);
    logic mis;
    case (sz)
      SZ_HALF: mis = lsb[0];
      SZ_WORD: mis = |lsb;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic int cnt_width(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Load extraction/extension and store lane steering. Lane i maps to byte address a+i;
// fetch[31:24] holds mem[a] (big-endian).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e            size,
  input  logic             sign_extend,
  input  logic [31:0]      fetch,
  input  logic [31:0]      store_data,
  output logic [31:0]      load_data,
  output logic [3:0]       byte_en,
  output logic [3:0][7:0]  store_lane
);

  always_comb begin
    load_data  = fetch;
    byte_en    = 4'b0000;
    store_lane = '0;
    case (size)
      SZ_BYTE: begin
        load_data     = {{24{sign_extend & fetch[31]}}, fetch[31:24]};
        byte_en       = 4'b0001;
        store_lane[0] = store_data[7:0];
      end
      SZ_HALF: begin
        load_data     = {{16{sign_extend & fetch[31]}}, fetch[31:16]};
        byte_en       = 4'b0011;
        store_lane[0] = store_data[15:8];
        store_lane[1] = store_data[7:0];
      end
      default: begin
        load_data     = fetch;
        byte_en       = 4'b1111;
        store_lane[0] = store_data[31:24];
        store_lane[1] = store_data[23:16];
        store_lane[2] = store_data[15:8];
        store_lane[3] = store_data[7:0];
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle big-endian data-memory responder with configurable wait states.
//   state | meaning
//   IDLE  | waiting for req; misaligned requests skip straight to RESP
//   BUSY  | wait-state countdown; access happens on the edge where cnt_q == 1
//   RESP  | ready (and misaligned if flagged) high for this single cycle
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [0:31] addr,
  input  logic [0:31] data_in,
  input  logic        write_enable,
  input  logic        mem_byte,
  input  logic        mem_half_word,
  input  logic        sign_extend,
  output logic [0:31] data_out,
  output logic        ready,
  output logic        misaligned
);

  localparam int AW = $clog2(SIZE);
  localparam int CW = cnt_width(LATENCY);

  logic [7:0] mem [0:SIZE-1];

  // Port vectors are MSB-first; plain assignment maps addr[31] onto addr_le[0].
  logic [31:0] addr_le;
  logic [31:0] data_in_le;
  logic        addr_unused;
  assign addr_le     = addr;
  assign data_in_le  = data_in;
  assign addr_unused = ^addr_le[31:AW];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mis_q, mis_d;
  logic [31:0]   dout_q, dout_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  size_e         size_q, size_d;
  logic          sext_q, sext_d;

  size_e         req_size;
  logic [AW-1:0] idx [4];
  logic [31:0]   fetch;
  logic [31:0]   load_data;
  logic [3:0]    byte_en;
  logic [3:0][7:0] store_lane;
  logic          last_wait;
  logic          commit;

  assign req_size  = decode_size(mem_byte, mem_half_word);
  assign last_wait = (state_q == ST_BUSY) && (cnt_q == CW'(1));
  assign commit    = last_wait && we_q && !reset;

  always_comb begin
    for (int i = 0; i < 4; i++) idx[i] = addr_q + AW'(i);
  end

  assign fetch = {mem[idx[0]], mem[idx[1]], mem[idx[2]], mem[idx[3]]};

  dmem_lane_align u_lane_align (
    .size        (size_q),
    .sign_extend (sext_q),
    .fetch       (fetch),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .byte_en     (byte_en),
    .store_lane  (store_lane)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (is_misaligned(req_size, addr_le[1:0])) begin
            mis_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            mis_d   = 1'b0;
            addr_d  = addr_le[AW-1:0];
            wdata_d = data_in_le;
            we_d    = write_enable;
            size_d  = req_size;
            sext_d  = sign_extend;
            cnt_d   = CW'(LATENCY);
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (last_wait) begin
          state_d = ST_RESP;
          if (!we_q) dout_d = load_data;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clock) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    we_q    <= we_d;
    size_q  <= size_d;
    sext_q  <= sext_d;
  end

  // Array is deliberately unreset so contents survive reset and can be preloaded.
  always_ff @(posedge clock) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx[i]] <= store_lane[i];
      end
    end
  end

  assign data_out   = dout_q;
  assign ready      = (state_q == ST_RESP);
  assign misaligned = (state_q == ST_RESP) && mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (SIZE=16384, LATENCY=2).
module tb_dmem_responder;

  logic        clock;
  logic        reset;
  logic        req;
  logic [0:31] addr;
  logic [0:31] data_in;
  logic        write_enable;
  logic        mem_byte;
  logic        mem_half_word;
  logic        sign_extend;
  logic [0:31] data_out;
  logic        ready;
  logic        misaligned;

  int total = 0;
  int bad   = 0;

  dmem_responder #(.SIZE(16384), .LATENCY(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .addr          (addr),
    .data_in       (data_in),
    .write_enable  (write_enable),
    .mem_byte      (mem_byte),
    .mem_half_word (mem_half_word),
    .sign_extend   (sign_extend),
    .data_out      (data_out),
    .ready         (ready),
    .misaligned    (misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Presents one request at a negedge, waits for ready, then idles one cycle so the
  // DUT is back in IDLE. lat = rising edges from presentation until ready is visible.
  task automatic access(input logic we, input logic mb, input logic mh, input logic se,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] dout, output logic mis,
                        output logic rdy_after);
    int   n;
    logic got;
    req = 1'b1; write_enable = we; mem_byte = mb; mem_half_word = mh;
    sign_extend = se; addr = a; data_in = d;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clock); @(negedge clock);
      n++;
      if (ready) got = 1'b1;
    end
    lat = n; dout = data_out; mis = misaligned;
    req = 1'b0;
    @(posedge clock); @(negedge clock);
    rdy_after = ready;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL access_timeout addr=%h: no ready seen, required within 20 cycles", a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; write_enable = 1'b0; mem_byte = 1'b0;
    mem_half_word = 1'b0; sign_extend = 1'b0; addr = '0; data_in = '0;
    repeat (3) @(negedge clock);
    total++; if (ready !== 1'b0)      begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned got=%b want=0", misaligned); end
    total++; if (data_out !== 32'h0)  begin bad++; $display("FAIL reset_data_out got=%h want=00000000", data_out); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_word_load();
    int lat; logic [31:0] d; logic m, ra;
    access(1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h0, lat, d, m, ra);
    total++; if (lat !== 3)          begin bad++; $display("FAIL word_load_latency got=%0d want=3", lat); end
    total++; if (d !== 32'h12345678) begin bad++; $display("FAIL word_load_data got=%h want=12345678", d); end
    total++; if (m !== 1'b0)         begin bad++; $display("FAIL word_load_mis got=%b want=0", m); end
    total++; if (ra !== 1'b0)        begin bad++; $display("FAIL word_load_ready_pulse got=%b want=0", ra); end
  endtask

  task automatic test_sign_ext();
    int lat; logic [31:0] d; logic m, ra;
    dut.mem[8194] = 8'h80; dut.mem[8195] = 8'h01;
    access(1'b0, 1'b1, 1'b0, 1'b1, 32'h2002, 32'h0, lat, d, m, ra);
    total++; if (d !== 32'hFFFFFF80) begin bad++; $display("FAIL byte_signed got=%h want=FFFFFF80", d); end
    access(1'b0, 1'b1, 1'b0, 1'b0, 32'h2002, 32'h0, lat, d, m, ra);
    total++; if (d !== 32'h00000080) begin bad++; $display("FAIL byte_unsigned got=%h want=00000080", d); end
    // mem_byte must win over mem_half_word
    access(1'b0, 1'b1, 1'b1, 1'b1, 32'h2002, 32'h0, lat, d, m, ra);
    total++; if (d !== 32'hFFFFFF80) begin bad++; $display("FAIL byte_priority got=%h want=FFFFFF80", d); end
    access(1'b0, 1'b0, 1'b1, 1'b1, 32'h2002, 32'h0, lat, d, m, ra);
    total++; if (d !== 32'hFFFF8001) begin bad++; $display("FAIL half_signed got=%h want=FFFF8001", d); end
    access(1'b0, 1'b0, 1'b1, 1'b0, 32'h2002, 32'h0, lat, d, m, ra);
    total++; if (d !== 32'h00008001) begin bad++; $display("FAIL half_unsigned got=%h want=00008001", d); end
    dut.mem[8194] = 8'h56; dut.mem[8195] = 8'h78;
  endtask

  task automatic test_store();
    int lat; logic [31:0] d; logic m, ra;
    access(1'b1, 1'b1, 1'b0, 1'b0, 32'h2001, 32'h555555AB, lat, d, m, ra);
    total++; if (data_out !== 32'h00008001) begin bad++; $display("FAIL store_holds_dout got=%h want=00008001", data_out); end
    total++; if (lat !== 3) begin bad++; $display("FAIL store_latency got=%0d want=3", lat); end
    access(1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h0, lat, d, m, ra);
    total++; if (d !== 32'h12AB5678) begin bad++; $display("FAIL byte_store_reload got=%h want=12AB5678", d); end
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h2002, 32'h1234CAFE, lat, d, m, ra);
    access(1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h0, lat, d, m, ra);
    total++; if (d !== 32'h12ABCAFE) begin bad++; $display("FAIL half_store_reload got=%h want=12ABCAFE", d); end
    total++; if (dut.mem[8196] !== 8'h00) begin bad++; $display("FAIL store_no_spill got=%h want=00", dut.mem[8196]); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] d; logic m, ra;
    access(1'b0, 1'b0, 1'b0, 1'b0, 32'h2001, 32'h0, lat, d, m, ra);
    total++; if (lat !== 1)          begin bad++; $display("FAIL mis_word_latency got=%0d want=1", lat); end
    total++; if (m !== 1'b1)         begin bad++; $display("FAIL mis_word_flag got=%b want=1", m); end
    total++; if (d !== 32'h12ABCAFE) begin bad++; $display("FAIL mis_word_dout got=%h want=12ABCAFE", d); end
    access(1'b0, 1'b0, 1'b1, 1'b0, 32'h2003, 32'h0, lat, d, m, ra);
    total++; if (lat !== 1 || m !== 1'b1) begin bad++; $display("FAIL mis_half lat=%0d mis=%b want lat=1 mis=1", lat, m); end
    access(1'b1, 1'b0, 1'b0, 1'b0, 32'h2002, 32'hFFFFFFFF, lat, d, m, ra);
    total++; if (m !== 1'b1) begin bad++; $display("FAIL mis_store_flag got=%b want=1", m); end
    access(1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h0, lat, d, m, ra);
    total++; if (d !== 32'h12ABCAFE || m !== 1'b0) begin bad++; $display("FAIL mis_store_mem got=%h mis=%b want=12ABCAFE mis=0", d, m); end
    access(1'b0, 1'b1, 1'b0, 1'b0, 32'h2003, 32'h0, lat, d, m, ra);
    total++; if (d !== 32'h000000FE || m !== 1'b0 || lat !== 3) begin
      bad++; $display("FAIL odd_byte got=%h mis=%b lat=%0d want=000000FE mis=0 lat=3", d, m, lat);
    end
  endtask

  task automatic test_reset_cancel();
    int lat; logic [31:0] d; logic m, ra;
    req = 1'b1; write_enable = 1'b1; mem_byte = 1'b0; mem_half_word = 1'b0;
    sign_extend = 1'b0; addr = 32'h2000; data_in = 32'hDEADBEEF;
    @(posedge clock); @(negedge clock);
    req = 1'b0;
    @(posedge clock); @(negedge clock);
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    total++; if (ready !== 1'b0)     begin bad++; $display("FAIL cancel_ready got=%b want=0", ready); end
    total++; if (data_out !== 32'h0) begin bad++; $display("FAIL cancel_dout got=%h want=00000000", data_out); end
    reset = 1'b0;
    @(negedge clock);
    access(1'b0, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h0, lat, d, m, ra);
    total++; if (d !== 32'h12ABCAFE) begin bad++; $display("FAIL cancel_reload got=%h want=12ABCAFE", d); end
    total++; if (lat !== 3) begin bad++; $display("FAIL cancel_idle_latency got=%0d want=3", lat); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] d; logic m, ra;
    dut.mem[8195] = 8'h5A;
    access(1'b0, 1'b0, 1'b0, 1'b0, 32'h00006000, 32'h0, lat, d, m, ra);
    total++; if (d !== 32'h12ABCA5A) begin bad++; $display("FAIL wrap_load got=%h want=12ABCA5A", d); end
    access(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF6003, 32'h000000FE, lat, d, m, ra);
    total++; if (dut.mem[8195] !== 8'hFE) begin bad++; $display("FAIL wrap_store got=%h want=FE", dut.mem[8195]); end
  endtask

  task automatic test_back_to_back();
    int pulses, first, second;
    pulses = 0; first = 0; second = 0;
    req = 1'b1; write_enable = 1'b0; mem_byte = 1'b0; mem_half_word = 1'b0;
    sign_extend = 1'b0; addr = 32'h2000; data_in = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clock); @(negedge clock);
      if (ready) begin
        pulses++;
        if (pulses == 1) first = c;
        if (pulses == 2) second = c;
      end
    end
    req = 1'b0;
    repeat (4) @(negedge clock);
    total++; if (pulses !== 3) begin bad++; $display("FAIL b2b_pulses got=%0d want=3", pulses); end
    total++; if (first !== 3 || second !== 7) begin
      bad++; $display("FAIL b2b_spacing got=%0d,%0d want=3,7", first, second);
    end
    total++; if (data_out !== 32'h12ABCAFE) begin bad++; $display("FAIL b2b_data got=%h want=12ABCAFE", data_out); end
  endtask

  initial begin
    test_reset();
    dut.mem[8192] = 8'h12; dut.mem[8193] = 8'h34;
    dut.mem[8194] = 8'h56; dut.mem[8195] = 8'h78;
    dut.mem[8196] = 8'h00;
    test_word_load();
    test_sign_ext();
    test_store();
    test_misaligned();
    test_reset_cancel();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
